// File: rtl/dma_req_pkg.sv
// Shared types and constants for the DMA request agent.
package dma_req_pkg;

    // Agent handshake states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Transfer mode encodings for the mode input
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BURST  = 1'b1;

    // Bits needed to hold values 0..max_val inclusive
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dma_req_timeout.sv
// Loadable up-counter with synchronous clear, count enable and a terminal
// flag. Used by the agent both as the acknowledge timeout and as the beat
// counter within a burst. Updates on the falling clock edge like the agent.
module dma_req_timeout #(
    parameter int          W    = 5,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         term
);

    logic [W-1:0] cnt_reg;

    // Counter register: clear beats load beats increment
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign term = (cnt_reg == TERM);

endmodule

// File: rtl/dma_req_agent.sv
// Device-side DMA request/acknowledge agent. Raises dreq for a loaded
// transfer length, counts beats on dack & data_ok, and reports end of
// block, controller early termination (tc), ack timeout and abort.
// All state changes on the falling clock edge to match the controller.
module dma_req_agent
    import dma_req_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int BURST  = 4,
    parameter int ACK_TO = 16,
    parameter int TO_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
    input  logic             abort,
    input  logic             data_ok,
    input  logic             dack,
    input  logic             tc,
    output logic             dreq,
    output logic             xfer_stb,
    output logic             eop,
    output logic             done,
    output logic             short_done,
    output logic             err,
    output logic             busy,
    output logic [LEN_W-1:0] remaining
);

    localparam int BW = width_for(BURST);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic             mode_reg, mode_next;
    logic             short_reg, short_next;
    logic             zero_done_reg, zero_done_next;

    logic             beat;
    logic             start_ok;
    logic             request_done;
    logic             to_clr, to_en, to_term;
    logic             burst_clr, burst_en, burst_term;
    logic [TO_W-1:0]  to_cnt;
    logic [BW-1:0]    burst_cnt;

    // A start is only honoured when the agent is not mid-transfer
    assign start_ok = start && !abort && (state_reg == IDLE || state_reg == ERR);

    // One beat moves when the controller acknowledges and the FIFO is ready
    assign beat = (state_reg == XFER) && dack && data_ok && !abort;

    // Request ends after one beat in single mode, or after the last burst beat
    assign request_done = (mode_reg == MODE_SINGLE) || burst_term;

    // Acknowledge timeout runs only while waiting in REQ
    assign to_clr = (state_reg != REQ) || dack;
    assign to_en  = (state_reg == REQ);

    // Burst beat count restarts whenever a new acknowledge is granted
    assign burst_clr = (state_reg == REQ) && dack;
    assign burst_en  = beat;

    dma_req_timeout #(
        .W    (TO_W),
        .TERM (TO_W'(ACK_TO - 1))
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (to_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (to_en),
        .cnt      (to_cnt),
        .term     (to_term)
    );

    dma_req_timeout #(
        .W    (BW),
        .TERM (BW'(BURST - 1))
    ) u_burst (
        .clk      (clk),
        .rst      (rst),
        .clr      (burst_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (burst_en),
        .cnt      (burst_cnt),
        .term     (burst_term)
    );

    // Counter values are only consumed through their terminal flags
    logic unused_cnts;
    assign unused_cnts = ^{to_cnt, burst_cnt};

    // State and datapath registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            mode_reg      <= MODE_SINGLE;
            short_reg     <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            mode_reg      <= mode_next;
            short_reg     <= short_next;
            zero_done_reg <= zero_done_next;
        end
    end

    // Next-state logic: abort wins over tc, which wins over normal flow
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        mode_next      = mode_reg;
        short_next     = short_reg;
        zero_done_next = 1'b0;

        if (beat && remaining_reg != '0) begin
            remaining_next = remaining_reg - 1'b1;
        end

        if (abort) begin
            state_next     = IDLE;
            remaining_next = '0;
            short_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE, ERR: begin
                    if (start_ok) begin
                        short_next = 1'b0;
                        if (len != '0) begin
                            remaining_next = len;
                            mode_next      = mode;
                            state_next     = REQ;
                        end else begin
                            // Empty transfer completes immediately without a request
                            zero_done_next = 1'b1;
                            state_next     = IDLE;
                        end
                    end
                end
                REQ: begin
                    if (tc) begin
                        state_next = DONE;
                        short_next = 1'b1;
                    end else if (dack) begin
                        state_next = XFER;
                    end else if (to_term) begin
                        state_next = ERR;
                    end
                end
                XFER: begin
                    if (tc) begin
                        state_next = DONE;
                        short_next = 1'b1;
                    end else if (!dack) begin
                        state_next = REQ;
                    end else if (beat) begin
                        if (remaining_reg == LEN_W'(1)) begin
                            state_next = DONE;
                        end else if (request_done) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tc) begin
                        state_next = DONE;
                        short_next = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    short_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        dreq       = (state_reg == REQ) || (state_reg == XFER);
        xfer_stb   = beat;
        eop        = beat && (remaining_reg == LEN_W'(1));
        done       = !abort && ((state_reg == DONE) || zero_done_reg);
        short_done = !abort && (state_reg == DONE) && short_reg;
        err        = (state_reg == ERR);
        busy       = (state_reg != IDLE) && (state_reg != ERR);
        remaining  = remaining_reg;
    end

endmodule

// File: tb/tb_dma_req_agent.sv
// Self-checking bench for dma_req_agent. Expected beats are queued when a
// transfer is started and popped as the agent strobes them.
module tb_dma_req_agent;

    localparam int LEN_W  = 8;
    localparam int BURST  = 4;
    localparam int ACK_TO = 16;
    localparam int TO_W   = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             mode;
    logic             abort;
    logic             data_ok;
    logic             dack;
    logic             tc;
    logic             dreq;
    logic             xfer_stb;
    logic             eop;
    logic             done;
    logic             short_done;
    logic             err;
    logic             busy;
    logic [LEN_W-1:0] remaining;

    typedef struct packed {
        logic [LEN_W-1:0] rem;
        logic             eop;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic             s_dreq, s_stb, s_eop, s_done, s_short, s_err, s_busy;
    logic [LEN_W-1:0] s_rem;

    dma_req_agent #(
        .LEN_W  (LEN_W),
        .BURST  (BURST),
        .ACK_TO (ACK_TO),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .mode       (mode),
        .abort      (abort),
        .data_ok    (data_ok),
        .dack       (dack),
        .tc         (tc),
        .dreq       (dreq),
        .xfer_stb   (xfer_stb),
        .eop        (eop),
        .done       (done),
        .short_done (short_done),
        .err        (err),
        .busy       (busy),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample on the rising edge (agent updates on the falling edge), score
    // any beat, then return just after the falling edge for new stimulus.
    task automatic tick();
        beat_t e;
        @(posedge clk);
        s_dreq  = dreq;
        s_stb   = xfer_stb;
        s_eop   = eop;
        s_done  = done;
        s_short = short_done;
        s_err   = err;
        s_busy  = busy;
        s_rem   = remaining;
        if (s_stb === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_beat got rem=%0d required no beat", s_rem);
            end else begin
                e = exp_q.pop_front();
                if (s_rem !== e.rem || s_eop !== e.eop) begin
                    errors++;
                    $display("FAIL sb_beat got rem=%0d eop=%0b required rem=%0d eop=%0b",
                             s_rem, s_eop, e.rem, e.eop);
                end else begin
                    $display("beat rem=%0d eop=%0b", s_rem, s_eop);
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input int l, input logic m);
        start = 1'b1;
        len   = LEN_W'(l);
        mode  = m;
        for (int i = l; i >= 1; i--) begin
            exp_q.push_back('{rem: LEN_W'(i), eop: (i == 1)});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, output int stb, output int gaps,
                                  output int gap_at, output int eops, output bit ok);
        stb = 0; gaps = 0; gap_at = -1; eops = 0; ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (s_stb === 1'b1) stb++;
            if (s_eop === 1'b1) eops++;
            if (s_busy === 1'b1 && s_dreq === 1'b0) begin
                gaps++;
                if (gap_at < 0) gap_at = stb;
            end
            if (s_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dreq, xfer_stb, eop, done, short_done, err, busy} !== 7'b0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b rem=%0d required 0", 
                     {dreq, xfer_stb, eop, done, short_done, err, busy}, remaining);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_burst();
        int stb, gaps, gap_at, eops;
        bit ok;
        dack = 1'b0; data_ok = 1'b1;
        start_xfer(8, 1'b1);
        tick();
        tick();
        checks++;
        if (s_dreq !== 1'b1) begin
            errors++; $display("FAIL burst_req_dreq got %b required 1", s_dreq);
        end
        dack = 1'b1;
        run_until_done(40, stb, gaps, gap_at, eops, ok);
        checks++;
        if (!ok || stb != 8 || gap_at != 4 || gaps != 2 || eops != 1) begin
            errors++;
            $display("FAIL burst_pattern got ok=%0b stb=%0d gap_at=%0d gaps=%0d eops=%0d required 1 8 4 2 1",
                     ok, stb, gap_at, gaps, eops);
        end
        checks++;
        if (s_rem !== '0 || s_short !== 1'b0) begin
            errors++; $display("FAIL burst_done got rem=%0d short=%b required 0 0", s_rem, s_short);
        end
        tick();
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL burst_done_pulse got done=%b busy=%b required 0 0", s_done, s_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL burst_queue got %0d left required 0", exp_q.size());
        end
        exp_q.delete();
        dack = 1'b0;
        $display("burst transfer len=8 complete");
    endtask

    task automatic test_single();
        int stb, gaps, gap_at, eops;
        bit ok;
        dack = 1'b1; data_ok = 1'b1;
        start_xfer(3, 1'b0);
        run_until_done(40, stb, gaps, gap_at, eops, ok);
        checks++;
        if (!ok || stb != 3 || gaps != 3 || gap_at != 1 || eops != 1 || s_short !== 1'b0) begin
            errors++;
            $display("FAIL single_pattern got ok=%0b stb=%0d gaps=%0d gap_at=%0d eops=%0d short=%b required 1 3 3 1 1 0",
                     ok, stb, gaps, gap_at, eops, s_short);
        end
        exp_q.delete();
        dack = 1'b0;
        $display("single transfer len=3 complete");
    endtask

    task automatic test_tc();
        int stb;
        int eops;
        dack = 1'b1; data_ok = 1'b1;
        start_xfer(10, 1'b0);
        stb = 0; eops = 0;
        for (int i = 0; i < 60 && stb < 5; i++) begin
            tick();
            if (s_stb === 1'b1) stb++;
            if (s_eop === 1'b1) eops++;
        end
        tc = 1'b1;
        tick();
        if (s_stb === 1'b1) stb++;
        tc = 1'b0;
        tick();
        checks++;
        if (stb != 5 || s_done !== 1'b1 || s_short !== 1'b1 || s_rem !== LEN_W'(5)) begin
            errors++;
            $display("FAIL tc_short got stb=%0d done=%b short=%b rem=%0d required 5 1 1 5",
                     stb, s_done, s_short, s_rem);
        end
        checks++;
        if (eops != 0 || s_eop !== 1'b0) begin
            errors++; $display("FAIL tc_no_eop got eops=%0d required 0", eops);
        end
        checks++;
        if (exp_q.size() != 5) begin
            errors++; $display("FAIL tc_queue got %0d left required 5", exp_q.size());
        end
        exp_q.delete();
        dack = 1'b0;
        $display("tc early termination complete");
    endtask

    task automatic test_timeout();
        int n;
        int stb, gaps, gap_at, eops;
        bit ok;
        dack = 1'b0; data_ok = 1'b1;
        start_xfer(6, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_err === 1'b1) break;
            if (s_dreq === 1'b1) n++;
        end
        checks++;
        if (s_err !== 1'b1 || n != ACK_TO || s_dreq !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got err=%b req_cycles=%0d dreq=%b busy=%b required 1 %0d 0 0",
                     s_err, n, s_dreq, s_busy, ACK_TO);
        end
        tick();
        tick();
        checks++;
        if (s_err !== 1'b1 || s_dreq !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky got err=%b dreq=%b required 1 0", s_err, s_dreq);
        end
        checks++;
        if (exp_q.size() != 6) begin
            errors++; $display("FAIL timeout_queue got %0d left required 6", exp_q.size());
        end
        exp_q.delete();
        dack = 1'b1;
        start_xfer(2, 1'b0);
        tick();
        checks++;
        if (s_err !== 1'b0 || s_dreq !== 1'b1) begin
            errors++; $display("FAIL timeout_restart got err=%b dreq=%b required 0 1", s_err, s_dreq);
        end
        run_until_done(30, stb, gaps, gap_at, eops, ok);
        checks++;
        if (!ok || stb != 2 || eops != 1) begin
            errors++; $display("FAIL timeout_recover got ok=%0b stb=%0d eops=%0d required 1 2 1", ok, stb, eops);
        end
        exp_q.delete();
        dack = 1'b0;
        $display("ack timeout and recovery complete");
    endtask

    task automatic test_data_ok();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        dack = 1'b1; data_ok = 1'b0;
        start_xfer(2, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            data_ok = pat[i];
            tick();
            checks++;
            if (s_stb !== pat[i] || s_eop !== (i == 3)) begin
                errors++;
                $display("FAIL data_ok_cycle%0d got stb=%b eop=%b required %b %b",
                         i, s_stb, s_eop, pat[i], (i == 3));
            end
        end
        data_ok = 1'b0;
        tick();
        checks++;
        if (s_done !== 1'b1 || s_short !== 1'b0) begin
            errors++; $display("FAIL data_ok_done got done=%b short=%b required 1 0", s_done, s_short);
        end
        exp_q.delete();
        dack = 1'b0;
        $display("data_ok wait states complete");
    endtask

    task automatic test_zero_len();
        start_xfer(0, 1'b0);
        tick();
        checks++;
        if (s_done !== 1'b1 || s_short !== 1'b0 || s_busy !== 1'b0 || s_dreq !== 1'b0) begin
            errors++;
            $display("FAIL zero_len got done=%b short=%b busy=%b dreq=%b required 1 0 0 0",
                     s_done, s_short, s_busy, s_dreq);
        end
        tick();
        checks++;
        if (s_done !== 1'b0) begin
            errors++; $display("FAIL zero_len_pulse got done=%b required 0", s_done);
        end
        $display("zero-length start complete");
    endtask

    task automatic test_abort_rst();
        dack = 1'b1; data_ok = 1'b1;
        start_xfer(5, 1'b1);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        checks++;
        if (s_stb !== 1'b0 || s_eop !== 1'b0 || s_done !== 1'b0) begin
            errors++; $display("FAIL abort_cycle got stb=%b eop=%b done=%b required 0 0 0", s_stb, s_eop, s_done);
        end
        abort = 1'b0;
        tick();
        checks++;
        if (s_rem !== '0 || s_busy !== 1'b0 || s_dreq !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got rem=%0d busy=%b dreq=%b done=%b required 0 0 0 0",
                     s_rem, s_busy, s_dreq, s_done);
        end
        checks++;
        if (exp_q.size() != 3) begin
            errors++; $display("FAIL abort_queue got %0d left required 3", exp_q.size());
        end
        exp_q.delete();
        dack = 1'b0;
        start_xfer(4, 1'b0);
        tick();
        checks++;
        if (s_dreq !== 1'b1) begin
            errors++; $display("FAIL rst_pre_req got dreq=%b required 1", s_dreq);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dreq, xfer_stb, eop, done, short_done, err, busy} !== 7'b0 || remaining !== '0) begin
            errors++;
            $display("FAIL rst_async got flags=%b rem=%0d required 0",
                     {dreq, xfer_stb, eop, done, short_done, err, busy}, remaining);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_dreq !== 1'b0) begin
            errors++; $display("FAIL rst_idle got busy=%b dreq=%b required 0 0", s_busy, s_dreq);
        end
        $display("abort and async reset complete");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; mode = 1'b0; abort = 1'b0;
        data_ok = 1'b0; dack = 1'b0; tc = 1'b0;
        test_reset();
        test_burst();
        test_single();
        test_tc();
        test_timeout();
        test_data_ok();
        test_zero_len();
        test_abort_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
